// File: rtl/mem_pkg.sv
// Shared definitions for the memory request front-end.
// Holds default widths, memory depth, the command bundle and a small index helper.
package mem_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH  = 16;
  localparam int OWNER_W    = 3;

  // Command bundle at default widths, for consumers that use them
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic [OWNER_W-1:0]    owner;
  } cmd_t;

  // Increment an index modulo n
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with its own pointer register.
// Ports: clk, rst (sync, active-high), req, advance -> one-hot grant, encoded idx.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               c;

  // Search starts at ptr and wraps; the first requester wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c[IDX_W-1:0]]) begin
        found                = 1'b1;
        grant[c[IDX_W-1:0]] = 1'b1;
        idx                  = c[IDX_W-1:0];
      end
    end
  end

  // The winner moves to lowest priority; no grant keeps ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= IDX_W'(wrap_inc(int'(idx), N));
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin front-end for one port of the shared memory, with a two-stage pipeline.
// Ports: client req_* handshakes in, registered mem_* command out, rsp_* read return.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS-1:0]        req_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_data_in,
  output logic                          mem_write_en,
  output logic                          mem_read_en,
  input  logic [DATA_W-1:0]             mem_data_out,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_data
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [IDX_W-1:0]  owner;
  } s1_t;

  logic [ADDR_W-1:0]      addr_a  [NUM_CLIENTS];
  logic [DATA_W-1:0]      wdata_a [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] req_m;
  logic [NUM_CLIENTS-1:0] grant;
  logic [IDX_W-1:0]       gidx;
  logic                   granted;
  s1_t                    s1;
  logic [IDX_W-1:0]       s2_owner;
  logic                   s2_rd;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Requests are masked during reset so nothing is granted
  assign req_m = rst ? '0 : req_valid;

  rr_arbiter #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_m),
    .advance (!rst),
    .grant   (grant),
    .idx     (gidx)
  );

  assign granted   = |grant;
  assign req_ready = grant;

  // Stage 1: command register; address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= granted;
      s1.we    <= granted && req_we[gidx];
      s1.rd    <= granted && !req_we[gidx];
      if (granted) begin
        s1.addr  <= addr_a[gidx];
        s1.wdata <= wdata_a[gidx];
        s1.owner <= gidx;
      end
    end
  end

  // Stage 2: tracks whose read data appears on mem_data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_owner <= '0;
      s2_rd    <= 1'b0;
    end else begin
      s2_owner <= s1.owner;
      s2_rd    <= s1.rd;
    end
  end

  // Enables are gated so an in-flight command never reaches memory in reset
  assign mem_address  = s1.addr;
  assign mem_data_in  = s1.wdata;
  assign mem_write_en = s1.valid && s1.we && !rst;
  assign mem_read_en  = s1.rd && !rst;

  always_comb begin
    rsp_valid = '0;
    if (s2_rd && !rst) rsp_valid[s2_owner] = 1'b1;
  end

  assign rsp_data = mem_data_out;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter with a 16x8 memory model and a reference scoreboard.
// Directed scenarios followed by randomized traffic with occasional resets.
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_data_in;
  logic            mem_write_en;
  logic            mem_read_en;
  logic [DW-1:0]   mem_data_out;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  logic [DW-1:0] ram [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      mem_data_out <= '0;
    end else begin
      if (mem_write_en) ram[mem_address] <= mem_data_in;
      if (mem_read_en) mem_data_out <= ram[mem_address];
    end
  end

  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rsp_t;

  bit            p_v  [N];
  bit            p_we [N];
  logic [AW-1:0] p_a  [N];
  logic [DW-1:0] p_d  [N];
  int            mptr;
  logic [DW-1:0] shadow [16];
  rsp_t          rq [$];
  bit            c_we;
  bit            c_re;
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_d;
  int            cyc;
  int            vectors;
  int            miscompares;
  logic [N-1:0]  seen_ready;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic post(input int c, input bit we, input int a, input int d);
    p_v[c]  = 1'b1;
    p_we[c] = we;
    p_a[c]  = AW'(a);
    p_d[c]  = DW'(d);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = p_v[i];
      req_we[i]              = p_we[i];
      req_addr[i*AW +: AW]   = p_a[i];
      req_wdata[i*DW +: DW]  = p_d[i];
    end
  endtask

  task automatic step();
    int           k;
    logic [N-1:0] pv;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    drive();
    @(negedge clk);
    for (int i = 0; i < N; i++) pv[i] = p_v[i];
    k  = rst ? -1 : pick(pv, mptr);
    eg = '0;
    if (k >= 0) eg[k] = 1'b1;
    seen_ready = req_ready;
    chk("ready", 32'(req_ready), 32'(eg));
    chk("wr_en", 32'(mem_write_en), 32'(c_we && !rst));
    chk("rd_en", 32'(mem_read_en), 32'(c_re && !rst));
    if (!rst && (c_we || c_re)) chk("addr", 32'(mem_address), 32'(c_a));
    if (!rst && c_we) chk("wdata", 32'(mem_data_in), 32'(c_d));
    er = '0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) er[rq[0].who] = 1'b1;
    chk("rsp_v", 32'(rsp_valid), 32'(er));
    if (er != '0) begin
      chk("rsp_d", 32'(rsp_data), 32'(rq[0].data));
      void'(rq.pop_front());
    end
    c_we = 1'b0;
    c_re = 1'b0;
    if (rst) begin
      mptr = 0;
      rq.delete();
      for (int i = 0; i < 16; i++) shadow[i] = '0;
    end else if (k >= 0) begin
      c_we = p_we[k];
      c_re = !p_we[k];
      c_a  = p_a[k];
      c_d  = p_d[k];
      if (p_we[k]) shadow[p_a[k]] = p_d[k];
      else rq.push_back('{cyc + 2, k, shadow[p_a[k]]});
      mptr   = (k + 1) % N;
      p_v[k] = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    bit b;
    b = c_we || c_re || (rq.size() > 0);
    for (int i = 0; i < N; i++) b = b || p_v[i];
    return b;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (busy() && n < 40) begin
      step();
      n++;
    end
    if (busy()) begin
      vectors++;
      miscompares++;
      $display("FAIL drain cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    mptr        = 0;
    c_we        = 1'b0;
    c_re        = 1'b0;
    c_a         = '0;
    c_d         = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    for (int i = 0; i < N; i++) post(i, 1'b0, 0, 0);

    // Reset held with every client requesting
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    drain();

    // Single client write then read back
    post(2, 1'b1, 5, 8'hA7);
    step();
    post(2, 1'b0, 5, 0);
    step();
    drain();

    // Fairness from ptr 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N; c++)
        if (!p_v[c]) post(c, 1'b0, $urandom_range(15), 0);
      step();
      chk("fair", 32'(seen_ready), 32'(1) << (i % 4));
    end
    drain();

    // Pointer at 3 with clients 1 and 3 competing
    rst = 1'b1;
    step();
    rst = 1'b0;
    post(2, 1'b0, 1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (!p_v[1]) post(1, 1'b0, 2, 0);
      if (!p_v[3]) post(3, 1'b0, 3, 0);
      step();
      chk("skip", 32'(seen_ready), (i % 2 == 0) ? 32'h8 : 32'h2);
    end
    drain();

    // Back-to-back read-after-write
    post(0, 1'b1, 9, 8'h3C);
    step();
    post(0, 1'b0, 9, 0);
    step();
    drain();

    // Reset while a read is in flight
    post(1, 1'b1, 6, 8'h55);
    step();
    drain();
    post(1, 1'b0, 6, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < N; c++) post(c, 1'b0, 6, 0);
    step();
    chk("ptr0", 32'(seen_ready), 32'h1);
    drain();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < N; c++)
        if (!p_v[c] && $urandom_range(1) == 1)
          post(c, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(255));
      rst = ($urandom_range(49) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
